// File: rtl/sensor_scheduler.sv
// Periodic sensor conversion scheduler: free-running sample tick, one-deep pending slot,
// round-robin or fixed channel select. Define SENSOR_SCHED_TIMEOUT_EN to abort stuck conversions.
module sensor_scheduler #(
    parameter int unsigned SAMPLE_PERIOD  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mode,
    input  logic        sns_done,
    input  logic [15:0] sns_data,
    output logic        sns_start,
    output logic [1:0]  sns_sel,
    output logic [15:0] result_data,
    output logic [1:0]  result_ch,
    output logic        result_valid,
    output logic [7:0]  overrun_cnt,
    output logic        timeout_err
);

    localparam int unsigned CNT_W  = $clog2(SAMPLE_PERIOD);
    localparam int unsigned WAIT_W = 16;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

`ifdef SENSOR_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic               pending;
    logic [1:0]         last_ch;
    logic [1:0]         next_ch;
    logic [WAIT_W-1:0]  wait_cnt;

    // Sample-period counter runs regardless of FSM state
    assign tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Fixed channel when mode is 1..3, otherwise successor of the last issued channel
    always_comb begin
        next_ch = 2'd1;
        if (mode inside {3'd1, 3'd2, 3'd3}) begin
            next_ch = mode[1:0];
        end else if (last_ch != 2'd3) begin
            next_ch = last_ch + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            pending      <= 1'b0;
            last_ch      <= 2'd3;
            wait_cnt     <= '0;
            sns_start    <= 1'b0;
            sns_sel      <= 2'd1;
            result_data  <= '0;
            result_ch    <= 2'd0;
            result_valid <= 1'b0;
            overrun_cnt  <= '0;
            timeout_err  <= 1'b0;
        end else begin
            sns_start    <= 1'b0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;

            // One pending slot; any tick that finds it occupied is dropped
            if (tick && pending && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (state == S_IDLE) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (tick || pending) begin
                        state     <= S_START;
                        sns_start <= 1'b1;
                        sns_sel   <= next_ch;
                        last_ch   <= next_ch;
                    end
                end
                S_START: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (sns_done) begin
                        state        <= S_LATCH;
                        result_data  <= sns_data;
                        result_ch    <= sns_sel;
                        result_valid <= 1'b1;
                    end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_LATCH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed bench for sensor_scheduler: cycle-level reference model compared every cycle,
// plus hand-computed literal checks for each scenario.
module tb_sensor_scheduler;

    localparam int P  = 8;
    localparam int TO = 5;
`ifdef SENSOR_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mode;
    logic        sns_done;
    logic [15:0] sns_data;
    logic        sns_start;
    logic [1:0]  sns_sel;
    logic [15:0] result_data;
    logic [1:0]  result_ch;
    logic        result_valid;
    logic [7:0]  overrun_cnt;
    logic        timeout_err;

    sensor_scheduler #(.SAMPLE_PERIOD(P), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .sns_done     (sns_done),
        .sns_data     (sns_data),
        .sns_start    (sns_start),
        .sns_sel      (sns_sel),
        .result_data  (result_data),
        .result_ch    (result_ch),
        .result_valid (result_valid),
        .overrun_cnt  (overrun_cnt),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: phase 0 idle, 1 start, 2 waiting, 3 latched
    int m_cnt, m_phase, m_pend, m_last, m_sel, m_data, m_ch, m_ovr, m_wait;
    int e_start, e_valid, e_terr;

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    task automatic model_update();
        int tick;
        int ph;
        int ch;
        if (reset) begin
            m_cnt = 0; m_phase = 0; m_pend = 0; m_last = 3; m_sel = 1;
            m_data = 0; m_ch = 0; m_ovr = 0; m_wait = 0;
            e_start = 0; e_valid = 0; e_terr = 0;
            return;
        end
        cyc++;
        tick  = (m_cnt == P - 1) ? 1 : 0;
        m_cnt = (m_cnt + 1) % P;
        ph    = m_phase;
        e_start = 0; e_valid = 0; e_terr = 0;
        if (tick == 1 && m_pend == 1) begin
            m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
        end else if (tick == 1 && ph != 0) begin
            m_pend = 1;
        end
        case (ph)
            0: if (tick == 1 || m_pend == 1) begin
                ch = (mode >= 3'd1 && mode <= 3'd3) ? int'(mode) : (m_last % 3) + 1;
                m_last = ch; m_sel = ch; m_pend = 0; e_start = 1; m_phase = 1;
            end
            1: begin m_phase = 2; m_wait = 0; end
            2: if (sns_done) begin
                m_data = int'(sns_data); m_ch = m_sel; e_valid = 1; m_phase = 3;
            end else begin
                m_wait++;
                if (TO_EN && m_wait == TO) begin e_terr = 1; m_phase = 0; end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        chk("sns_start",    int'(sns_start),    e_start);
        chk("sns_sel",      int'(sns_sel),      m_sel);
        chk("result_data",  int'(result_data),  m_data);
        chk("result_ch",    int'(result_ch),    m_ch);
        chk("result_valid", int'(result_valid), e_valid);
        chk("overrun_cnt",  int'(overrun_cnt),  m_ovr);
        chk("timeout_err",  int'(timeout_err),  e_terr);
    endtask

    // Every clock advance goes through here: model at the edge, compare 1ns later
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_start();
        int found;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (sns_start) found = 1;
            else step();
        end
        if (found == 0 && sns_start) found = 1;
        chk("wait_start_seen", found, 1);
    endtask

    task automatic pulse_done(input logic [15:0] d);
        sns_done = 1'b1;
        sns_data = d;
        step();
        sns_done = 1'b0;
        sns_data = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ch[4];
        int s;
        int lv;
        int seen;
        exp_ch[0] = 1; exp_ch[1] = 2; exp_ch[2] = 3; exp_ch[3] = 1;
        reset = 1'b1; mode = 3'd0; sns_done = 1'b0; sns_data = 16'h0000;
        steps(3);
        chk("rst_sns_start", int'(sns_start), 0);
        chk("rst_sns_sel", int'(sns_sel), 1);
        chk("rst_result_data", int'(result_data), 0);
        chk("rst_overrun", int'(overrun_cnt), 0);
        reset = 1'b0;
        cyc = 1;

        // Auto round-robin; modes 4..7 behave like 0
        for (int k = 0; k < 4; k++) begin
            mode = (k < 2) ? 3'd0 : 3'd7;
            wait_start();
            if (k == 0) chk("first_start_cycle", cyc, 9);
            chk("rr_sel", int'(sns_sel), exp_ch[k]);
            steps(2);
            pulse_done(16'h0A01 + 16'(k));
            chk("rr_valid", int'(result_valid), 1);
            chk("rr_result_ch", int'(result_ch), exp_ch[k]);
            chk("rr_result_data", int'(result_data), 16'h0A01 + k);
        end
        step();
        pulse_done(16'hBEEF);
        chk("stray_done_ignored", int'(result_data), 16'h0A04);

        // Fixed channel, mode changed mid-conversion
        mode = 3'd2;
        wait_start();
        chk("fixed_sel", int'(sns_sel), 2);
        step();
        mode = 3'd3;
        step();
        pulse_done(16'h2222);
        chk("fixed_result_ch", int'(result_ch), 2);
        chk("fixed_result_data", int'(result_data), 16'h2222);
        wait_start();
        chk("fixed_next_sel", int'(sns_sel), 3);
        steps(2);
        pulse_done(16'h3333);
        chk("fixed_next_ch", int'(result_ch), 3);

`ifndef SENSOR_SCHED_TIMEOUT_EN
        // Withheld done: one tick pends, the next is dropped
        mode = 3'd1;
        wait_start();
        steps(20);
        pulse_done(16'h1111);
        chk("ovr_count", int'(overrun_cnt), 1);
        chk("ovr_valid", int'(result_valid), 1);
        lv = cyc;
        wait_start();
        chk("ovr_restart_gap", cyc - lv, 2);
        chk("ovr_restart_sel", int'(sns_sel), 1);
        steps(2);
        pulse_done(16'h1112);
        chk("ovr_count_hold", int'(overrun_cnt), 1);
`else
        // No done: abort after the wait limit, result untouched, sequence advanced
        mode = 3'd0;
        wait_start();
        chk("to_sel", int'(sns_sel), 1);
        s = cyc;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            step();
            if (timeout_err) seen = 1;
        end
        chk("to_seen", seen, 1);
        chk("to_latency", cyc - s, 6);
        chk("to_result_kept", int'(result_data), 16'h3333);
        wait_start();
        chk("to_next_sel", int'(sns_sel), 2);
        steps(2);
        pulse_done(16'h4444);
        chk("to_after_data", int'(result_data), 16'h4444);
`endif

        // Reset mid-conversion, late done must be ignored
        mode = 3'd0;
        wait_start();
        step();
        reset = 1'b1;
        steps(2);
        chk("mid_rst_start", int'(sns_start), 0);
        chk("mid_rst_sel", int'(sns_sel), 1);
        reset = 1'b0;
        cyc = 1;
        step();
        pulse_done(16'h5555);
        chk("late_done_valid", int'(result_valid), 0);
        chk("late_done_data", int'(result_data), 0);
        wait_start();
        chk("post_rst_start_cycle", cyc, 9);
        chk("post_rst_sel", int'(sns_sel), 1);
        steps(2);
        pulse_done(16'h6666);
        chk("post_rst_data", int'(result_data), 16'h6666);
        chk("post_rst_ch", int'(result_ch), 1);
        steps(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
